// File: rtl/rram_ctrl_pkg.sv
// Shared definitions for the RRAM page controller: FSM states, default widths
// and the command bit sent during the CMD phase.
package rram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_XFER,
    S_DONE
  } state_t;

  localparam int WORD_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/rram_bit_cnt.sv
// Up-counter with clear and enable; o_tc flags the enabled cycle whose count
// equals i_last, so the owner can leave the phase on that edge.
module rram_bit_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      o_cnt <= '0;
    else if (i_clr)  o_cnt <= '0;
    else if (i_en)   o_cnt <= o_cnt + 1'b1;
  end

  assign o_tc = i_en && (o_cnt == i_last);

endmodule

// File: rtl/rram_page_ctrl.sv
// Serial page controller for an RRAM array: CMD bit, MSB-first address, then one
// data bit per cycle indexed by register_add; reads assemble rdata from sdi.
module rram_page_ctrl
  import rram_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              abort,
  output logic [WORD_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              aborted,
  output logic              ce_n,
  output logic              cle,
  output logic              ale,
  output logic              we_n,
  output logic              re_n,
  output logic [ADDR_W-1:0] register_add,
  output logic              sdo,
  output logic              sdo_oe,
  input  logic              sdi
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_W - 1);
  localparam logic [ADDR_W-1:0] XFER_LAST = ADDR_W'(WORD_W - 1);

  state_t              r_state, w_next;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_rdata;
  logic                r_aborted;

  logic                w_accept, w_busy, w_abort;
  logic                w_cnt_en, w_cnt_clr, w_tc;
  logic [ADDR_W-1:0]   w_cnt, w_last;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_busy    = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_XFER);
  assign w_abort   = abort && w_busy;
  assign w_cnt_en  = (r_state == S_ADDR) || (r_state == S_XFER);
  // Clearing on terminal count restarts the counter at 0 for the XFER phase.
  assign w_cnt_clr = !w_cnt_en || w_tc || w_abort;
  assign w_last    = (r_state == S_ADDR) ? ADDR_LAST : XFER_LAST;

  rram_bit_cnt #(.W(ADDR_W)) u_bit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_last (w_last),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wr      <= CMD_READ;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aborted <= w_abort;
      if (w_accept) begin
        r_wr    <= req_wr;
        r_addr  <= req_addr;
        r_wdata <= wdata;
      end else if (r_state == S_ADDR) begin
        // Address goes out MSB first, so shift the latched copy left.
        r_addr  <= r_addr << 1;
      end
      if ((r_state == S_XFER) && (r_wr == CMD_READ) && !w_abort)
        r_rdata[w_cnt] <= sdi;
    end
  end

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    ce_n         = 1'b1;
    cle          = 1'b0;
    ale          = 1'b0;
    we_n         = 1'b1;
    re_n         = 1'b1;
    sdo          = 1'b0;
    sdo_oe       = 1'b0;
    register_add = '0;
    rdata_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_CMD;
      end
      S_CMD: begin
        ce_n   = 1'b0;
        cle    = 1'b1;
        we_n   = 1'b0;
        sdo_oe = 1'b1;
        sdo    = r_wr;
        w_next = S_ADDR;
      end
      S_ADDR: begin
        ce_n   = 1'b0;
        ale    = 1'b1;
        we_n   = 1'b0;
        sdo_oe = 1'b1;
        sdo    = r_addr[ADDR_W-1];
        if (w_tc) w_next = S_XFER;
      end
      S_XFER: begin
        ce_n         = 1'b0;
        register_add = w_cnt;
        if (r_wr == CMD_WRITE) begin
          we_n   = 1'b0;
          sdo_oe = 1'b1;
          sdo    = r_wdata[w_cnt];
        end else begin
          re_n   = 1'b0;
        end
        if (w_tc) w_next = S_DONE;
      end
      S_DONE: begin
        rdata_valid = (r_wr == CMD_READ);
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  assign done    = (r_state == S_DONE) || r_aborted;
  assign aborted = r_aborted;
  assign rdata   = r_rdata;

endmodule
